// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data RAM initiator.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    WR       = 3'd3,
    ERR      = 3'd4
  } state_t;

  // Request attributes held for the lifetime of one transaction.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
  } req_attr_t;

  // Misaligned half/word accesses and the reserved size code are rejected.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word store data into a word.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    ld_data  = word;
    st_word  = wdata;
    case (size)
      SZ_BYTE: begin
        ld_data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        st_word = word;
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        st_word = word;
        st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = word;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data RAM with registered read; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              ram_W_en,
  output logic [ADDR_W-1:0] ram_Wr_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_R_en,
  output logic [ADDR_W-1:0] ram_Read_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state, state_next;
  req_attr_t         attr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] merge_q;
  logic              accept;
  logic              bad;
  logic              load_done;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  mem_access_unit_lane_align u_lane_align (
    .word    (ram_dout),
    .wdata   (merge_q),
    .lane    (attr_q.lane),
    .size    (attr_q.size),
    .uns     (attr_q.uns),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // Next state plus RAM-side decode; RAM outputs depend only on state and latched request.
  always_comb begin
    state_next    = state;
    accept        = req_valid & req_ready;
    bad           = size_err(req_size, req_addr[1:0]);
    load_done     = (state == RD_DATA) && !attr_q.we;
    ram_W_en      = 1'b0;
    ram_Wr_addr   = '0;
    ram_din       = '0;
    ram_R_en      = 1'b0;
    ram_Read_addr = '0;
    stall         = req_valid & ~req_ready & ~rst;

    case (state)
      IDLE: begin
        if (accept) begin
          if (bad)                                 state_next = ERR;
          else if (req_we && req_size == SZ_WORD)  state_next = WR;
          else                                     state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        state_next    = RD_DATA;
        ram_R_en      = 1'b1;
        ram_Read_addr = waddr_q;
      end
      RD_DATA:  state_next = attr_q.we ? WR : IDLE;
      WR: begin
        state_next  = IDLE;
        ram_W_en    = 1'b1;
        ram_Wr_addr = waddr_q;
        ram_din     = merge_q;
      end
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake and response registers; response fields hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= load_done || (state == WR) || (state == ERR);
      if (load_done) begin
        rsp_rdata <= ld_data;
        rsp_err   <= 1'b0;
      end else if (state == WR || state == ERR) begin
        rsp_rdata <= '0;
        rsp_err   <= (state == ERR);
      end
    end
  end

  // Request capture at accept; merge_q starts as store data and becomes the merged word for sub-word stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attr_q  <= '0;
      waddr_q <= '0;
      merge_q <= '0;
    end else if (accept) begin
      attr_q  <= '{we: req_we, size: req_size, uns: req_unsigned, lane: req_addr[1:0]};
      waddr_q <= req_addr[ADDR_W+1:2];
      merge_q <= req_wdata;
    end else if (state == RD_DATA && attr_q.we) begin
      merge_q <= st_word;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural registered-read data RAM behind it.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              stall;
  logic              ram_W_en;
  logic [ADDR_W-1:0] ram_Wr_addr;
  logic [31:0]       ram_din;
  logic              ram_R_en;
  logic [ADDR_W-1:0] ram_Read_addr;
  logic [31:0]       ram_dout;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .stall         (stall),
    .ram_W_en      (ram_W_en),
    .ram_Wr_addr   (ram_Wr_addr),
    .ram_din       (ram_din),
    .ram_R_en      (ram_R_en),
    .ram_Read_addr (ram_Read_addr),
    .ram_dout      (ram_dout)
  );

  always #5 clk = ~clk;

  // dataRAM model: synchronous write, registered read
  logic [31:0] mem [2**ADDR_W];
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_W_en) mem[ram_Wr_addr] <= ram_din;
    if (ram_R_en) ram_dout <= mem[ram_Read_addr];
  end

  // RAM port activity, sampled mid-cycle
  int          tot_wen = 0;
  int          tot_ren = 0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_din = '0;
  always @(negedge clk) begin
    if (ram_W_en) begin
      tot_wen++;
      last_waddr = ram_Wr_addr;
      last_din   = ram_din;
    end
    if (ram_R_en) tot_ren++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wen;
    int          exp_ren;
    logic [7:0]  exp_waddr;
    logic [31:0] exp_din;
  } vec_t;

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                              input int exp_wen, input int exp_ren, input logic [7:0] exp_waddr,
                              input logic [31:0] exp_din);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wen = exp_wen; v.exp_ren = exp_ren; v.exp_waddr = exp_waddr; v.exp_din = exp_din;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge of the rsp_valid cycle (or on timeout).
  task automatic do_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output int lat, output int wen, output int ren);
    int wen0, ren0;
    wen0 = tot_wen;
    ren0 = tot_ren;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check({name, ".stall"}, 32'(stall), 32'd1);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    wen = tot_wen - wen0;
    ren = tot_ren - ren0;
  endtask

  vec_t vecs[17];
  int   lat, wen, ren, cnt;
  logic seen;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("sw_010",  1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 2, 1, 0, 8'h04, 32'hDEADBEEF);
    vecs[1]  = mk("lb_013",  0, 2'b00, 0, 10'h013, 32'h0,        32'hFFFFFFDE, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[2]  = mk("lbu_013", 0, 2'b00, 1, 10'h013, 32'h0,        32'h000000DE, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[3]  = mk("lh_012",  0, 2'b01, 0, 10'h012, 32'h0,        32'hFFFFDEAD, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[4]  = mk("lhu_010", 0, 2'b01, 1, 10'h010, 32'h0,        32'h0000BEEF, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[5]  = mk("lb_010",  0, 2'b00, 0, 10'h010, 32'h0,        32'hFFFFFFEF, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[6]  = mk("lw_012",  0, 2'b10, 0, 10'h012, 32'h0,        32'h0,        1, 2, 0, 0, 8'h00, 32'h0);
    vecs[7]  = mk("lw_010",  0, 2'b10, 0, 10'h010, 32'h0,        32'hDEADBEEF, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[8]  = mk("sh_011",  1, 2'b01, 0, 10'h011, 32'h1234,     32'h0,        1, 2, 0, 0, 8'h00, 32'h0);
    vecs[9]  = mk("sz11",    0, 2'b11, 0, 10'h010, 32'h0,        32'h0,        1, 2, 0, 0, 8'h00, 32'h0);
    vecs[10] = mk("sb_011",  1, 2'b00, 0, 10'h011, 32'hAAAAAA55, 32'h0,        0, 4, 1, 1, 8'h04, 32'hDEAD55EF);
    vecs[11] = mk("lw_b2b",  0, 2'b10, 0, 10'h010, 32'h0,        32'hDEAD55EF, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[12] = mk("sh_012",  1, 2'b01, 0, 10'h012, 32'h0000CAFE, 32'h0,        0, 4, 1, 1, 8'h04, 32'hCAFE55EF);
    vecs[13] = mk("lw_merge",0, 2'b10, 0, 10'h010, 32'h0,        32'hCAFE55EF, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[14] = mk("sw_top",  1, 2'b10, 0, 10'h3FC, 32'h11223344, 32'h0,        0, 2, 1, 0, 8'hFF, 32'h11223344);
    vecs[15] = mk("lbu_top", 0, 2'b00, 1, 10'h3FF, 32'h0,        32'h00000011, 0, 3, 0, 1, 8'h00, 32'h0);
    vecs[16] = mk("lh_top",  0, 2'b01, 0, 10'h3FC, 32'h0,        32'h00003344, 0, 3, 0, 1, 8'h00, 32'h0);

    // Reset: everything low, stall masked even with a pending request
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst.ready",     32'(req_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.stall",     32'(stall),     32'd0);
    check("rst.w_en",      32'(ram_W_en),  32'd0);
    check("rst.r_en",      32'(ram_R_en),  32'd0);
    check("rst.rdata",     rsp_rdata,      32'd0);
    check("rst.err",       32'(rsp_err),   32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rel.ready", 32'(req_ready), 32'd1);

    // Reset pulse while idle
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("pulse.ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("pulse.rel_ready", 32'(req_ready), 32'd1);

    // Directed table, issued back-to-back
    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             lat, wen, ren);
      check({vecs[i].name, ".lat"},   32'(lat),        32'(vecs[i].exp_lat));
      check({vecs[i].name, ".rdata"}, rsp_rdata,       vecs[i].exp_rdata);
      check({vecs[i].name, ".err"},   32'(rsp_err),    32'(vecs[i].exp_err));
      check({vecs[i].name, ".wen"},   32'(wen),        32'(vecs[i].exp_wen));
      check({vecs[i].name, ".ren"},   32'(ren),        32'(vecs[i].exp_ren));
      if (vecs[i].exp_wen > 0) begin
        check({vecs[i].name, ".waddr"}, 32'(last_waddr), 32'(vecs[i].exp_waddr));
        check({vecs[i].name, ".din"},   last_din,        vecs[i].exp_din);
      end
    end

    // Response must be a single-cycle pulse
    @(negedge clk);
    check("pulse.rsp_valid", 32'(rsp_valid), 32'd0);

    // SH aborted by reset during its WR cycle: write lost, no response
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 10'h010; req_wdata = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!ram_W_en && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("abort.wr_seen", 32'(ram_W_en), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.w_en_drop", 32'(ram_W_en),  32'd0);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("abort.no_rsp", 32'(seen), 32'd0);
    do_req("lw_after_abort", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, lat, wen, ren);
    check("lw_after_abort.lat",   32'(lat), 32'd3);
    check("lw_after_abort.rdata", rsp_rdata, 32'hCAFE55EF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
